lm_sm_sequencer: RTL
====================

Name: lm_sm_sequencer

Overview:
Controller that sequences the data memory for multi-register load (LM) and store (SM) instructions. It takes ownership of the memory-stage address and write-enable paths for N consecutive cycles, walks the 8-bit register mask, and stalls the upstream pipeline while busy. It sits beside the memory stage; its mem_* outputs are muxed onto the data memory ports whenever busy is high.

Parameters:
DATA_W, 16, width of address, data and register values
NUM_REGS, 8, register-file entries and mask width
IDX_W, 3, register index width (log2 NUM_REGS)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous active-low reset
start  in  1  one-cycle request: LM/SM instruction ready in memory stage
is_store  in  1  1 = SM, 0 = LM; sampled with start
reg_mask  in  NUM_REGS  bit i set = transfer Ri; sampled with start
base_addr  in  DATA_W  start address (RA value); sampled with start
mem_rdata  in  DATA_W  data memory read output (combinational read)
mem_addr  out  DATA_W  data memory address while busy
mem_write_en  out  1  data memory write enable (SM only)
rf_read_idx  out  IDX_W  register whose value is driven to memory writeData (SM)
rf_write_en  out  1  register-file write strobe (LM)
rf_write_idx  out  IDX_W  register-file write index (LM)
rf_write_data  out  DATA_W  register-file write data (LM)
busy  out  1  sequencer owns the memory ports
stall_req  out  1  freeze fetch..execute stages
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, active-low): state IDLE; all outputs 0; pending mask, address, counters cleared. Asserting reset mid-operation abandons the transfer: no further accesses, no done pulse. Next start after release is serviced normally.
- States: IDLE, ACCESS, DRAIN.
- IDLE: start sampled at edge T. If reg_mask != 0, go to ACCESS and latch mask, base_addr, is_store. If reg_mask == 0, stay IDLE, pulse done at T+1, no memory access, busy stays 0.
- ACCESS (cycles T+1 .. T+N, N = popcount(mask)): each cycle selects the lowest set bit i of the remaining mask, drives mem_addr = base + k (k = 0..N-1, modulo 2^16, so 0xFFFF+1 = 0x0000), and clears bit i at the edge.
  - SM: mem_write_en = 1, rf_read_idx = i.
  - LM: mem_write_en = 0; at the edge mem_rdata, i register into rf_write_data/idx with rf_write_en = 1 for the following cycle (load writeback latency 1).
  - Last bit: SM → IDLE, done at T+N+1. LM → DRAIN.
- DRAIN (LM only, cycle T+N+1): final writeback visible; next edge → IDLE, done at T+N+2.
- busy = (state != IDLE). stall_req = busy | start (combinational, so the stall takes effect in the start cycle). Outputs mem_write_en, rf_write_en are 0 whenever not in the relevant state.
- start while busy is ignored; upstream must not assert it (stall_req guarantees this).
- done is registered, exactly one cycle, never coincident with busy = 1.
- Register indices are processed strictly ascending; addresses strictly consecutive regardless of mask gaps.

Decomposition:
- Shared header lm_sm_defs.vh: state encodings (IDLE/ACCESS/DRAIN), NUM_REGS, IDX_W, DATA_W.
- One sub-module: lowest_set_bit_enc (NUM_REGS-bit mask → IDX_W index + valid + one-hot clear mask), combinational.

Test Plan:
- SM, mask 0x05, base 0x0010, start at T → T+1: addr 0x0010, we=1, rf_read_idx 0; T+2: addr 0x0011, we=1, idx 2; done at T+3; busy high T+1..T+2; stall_req high T..T+2.
- LM, mask 0x81, base 0x0020, memory holds 0xAAAA@0x0020, 0xBBBB@0x0021 → rf_write R0=0xAAAA at T+2, R7=0xBBBB at T+3; mem_write_en never 1; done at T+4.
- mask 0x00 (either op) → no mem_write_en/rf_write_en, busy stays 0, stall_req only at T, done at T+1.
- LM, mask 0xFF, base 0xFFFE → addresses FFFE, FFFF, 0000..0005 on T+1..T+8; writebacks R0..R7 on T+2..T+9; done at T+10.
- start pulsed again during busy → ignored, original sequence unchanged. Reset asserted after 3rd LM access → all outputs 0 immediately, no done. Fresh SM mask 0x02 after release completes with done.

Source files
------------

// File: rtl/lm_sm_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lm_sm_sequencer_pkg
//  Purpose  : Shared sizes and FSM state encoding for the LM/SM sequencer.
//  Contents : DATA_W, NUM_REGS, IDX_W defaults; state_t (IDLE/ACCESS/DRAIN).
//  Revision : 1.0 - initial release
// ============================================================================
package lm_sm_sequencer_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int IDX_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lm_sm_sequencer_lowest_set_bit_enc.sv
`default_nettype none
// ============================================================================
//  Module   : lowest_set_bit_enc
//  Purpose  : Combinational priority encoder selecting the lowest set bit of
//             a register mask.
//  Ports    : mask   - input register mask
//             idx    - index of the lowest set bit (0 when mask is empty)
//             valid  - mask has at least one bit set
//             onehot - one-hot vector of the selected bit (bit to clear)
//  Revision : 1.0 - initial release
// ============================================================================
module lowest_set_bit_enc #(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3
) (
    input  logic [NUM_REGS-1:0] mask,
    output logic [IDX_W-1:0]    idx,
    output logic                valid,
    output logic [NUM_REGS-1:0] onehot
);

    // Scanning from the top down lets the lowest set bit win last.
    always_comb begin
        idx    = '0;
        onehot = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx       = IDX_W'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

    assign valid = |mask;

endmodule
`default_nettype wire

// File: rtl/lm_sm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : lm_sm_sequencer
//  Purpose  : Sequences the data memory for multi-register load (LM) and
//             store (SM). Walks the register mask lowest-first, issuing one
//             access per set bit at consecutive addresses, and stalls the
//             upstream pipeline while it owns the memory ports.
//  Ports    : clk, reset (async, active-low)
//             start, is_store, reg_mask, base_addr  - request (sampled on start)
//             mem_rdata                             - data memory read data
//             mem_addr, mem_write_en                - data memory control
//             rf_read_idx                           - store source register
//             rf_write_en/idx/data                  - load writeback
//             busy, stall_req, done                 - status
//  Revision : 1.0 - initial release
// ============================================================================
module lm_sm_sequencer
    import lm_sm_sequencer_pkg::*;
#(
    parameter int DATA_W   = lm_sm_sequencer_pkg::DATA_W,
    parameter int NUM_REGS = lm_sm_sequencer_pkg::NUM_REGS,
    parameter int IDX_W    = lm_sm_sequencer_pkg::IDX_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                is_store,
    input  logic [NUM_REGS-1:0] reg_mask,
    input  logic [DATA_W-1:0]   base_addr,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [DATA_W-1:0]   mem_addr,
    output logic                mem_write_en,
    output logic [IDX_W-1:0]    rf_read_idx,
    output logic                rf_write_en,
    output logic [IDX_W-1:0]    rf_write_idx,
    output logic [DATA_W-1:0]   rf_write_data,
    output logic                busy,
    output logic                stall_req,
    output logic                done
);

    state_t              r_state;
    logic [NUM_REGS-1:0] r_mask;
    logic [DATA_W-1:0]   r_addr;
    logic                r_is_store;
    logic                r_done;
    logic                r_rf_we;
    logic [IDX_W-1:0]    r_rf_idx;
    logic [DATA_W-1:0]   r_rf_data;

    logic [IDX_W-1:0]    w_idx;
    logic                w_valid;
    logic [NUM_REGS-1:0] w_onehot;
    logic [NUM_REGS-1:0] w_next_mask;
    logic                w_last;
    logic                w_access;

    lowest_set_bit_enc #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_lsb_enc (
        .mask   (r_mask),
        .idx    (w_idx),
        .valid  (w_valid),
        .onehot (w_onehot)
    );

    assign w_next_mask = r_mask & ~w_onehot;
    assign w_last      = (w_next_mask == '0);
    assign w_access    = (r_state == ST_ACCESS) && w_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_mask     <= '0;
            r_addr     <= '0;
            r_is_store <= 1'b0;
            r_done     <= 1'b0;
            r_rf_we    <= 1'b0;
            r_rf_idx   <= '0;
            r_rf_data  <= '0;
        end else begin
            r_done  <= 1'b0;
            r_rf_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (reg_mask != '0) begin
                            r_state    <= ST_ACCESS;
                            r_mask     <= reg_mask;
                            r_addr     <= base_addr;
                            r_is_store <= is_store;
                        end else begin
                            // Empty mask: nothing to move, just acknowledge.
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_mask <= w_next_mask;
                    // Address advances once per access, independent of mask
                    // gaps; natural wrap at 2^DATA_W.
                    r_addr <= r_addr + DATA_W'(1);
                    if (!r_is_store) begin
                        r_rf_we   <= 1'b1;
                        r_rf_idx  <= w_idx;
                        r_rf_data <= mem_rdata;
                    end
                    if (w_last) begin
                        if (r_is_store) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            // One extra cycle so the last load writeback is
                            // visible while the pipeline is still stalled.
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = (r_state != ST_IDLE);
    // Start is folded in combinationally so the stall covers the request cycle.
    assign stall_req     = busy | start;
    assign done          = r_done;
    assign mem_addr      = w_access ? r_addr : '0;
    assign mem_write_en  = w_access & r_is_store;
    assign rf_read_idx   = (w_access && r_is_store) ? w_idx : '0;
    assign rf_write_en   = r_rf_we;
    assign rf_write_idx  = r_rf_idx;
    assign rf_write_data = r_rf_data;

endmodule
`default_nettype wire
